pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline.
- Inspects stage-register and stage-output fields and drives the stall and bubble controls of the F/D/E/M/W pipeline registers, plus condition-code write enable.
- Handles load/use hazards, ret stalls, jXX mispredicts and exception/halt draining.
- Adds a post-reset boot flush and a sticky halt state, so the pipeline registers never need reset values.

Parameters:
- BOOT_CYCLES, 4: cycles after reset release during which D/E/M are bubbled and F is stalled; legal range 1..15.
- STAT_W, 3: width of the status fields.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- D_icode  input  4  icode in D register
- d_srcA  input  4  decode srcA (15 = none)
- d_srcB  input  4  decode srcB (15 = none)
- E_icode  input  4  icode in E register
- E_dstM  input  4  dstM in E register
- e_Cnd  input  1  execute-stage branch condition
- M_icode  input  4  icode in M register
- m_stat  input  STAT_W  memory-stage status
- W_stat  input  STAT_W  status in W register
- F_stall  output  1  hold F (PC) register
- D_stall  output  1  hold D register
- D_bubble  output  1  load nop into D
- E_bubble  output  1  load nop into E
- M_bubble  output  1  load nop into M
- W_stall  output  1  hold W register
- set_cc  output  1  allow CC update this cycle
- halted  output  1  FSM in HALT
- cpu_stat  output  STAT_W  latched final status (1 AOK, 2 ADR, 3 INS, 4 HLT)
- perf_cycles, perf_stalls, perf_mispred  output  32 each  performance counters (see Optional Feature)

Behaviour:
Encodings used:
- icodes: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=11.
- Exception status = stat in {2,3,4}.

Combinational terms:
- lu = E_icode in {5,11} && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB).
- ret = 9 in {D_icode, E_icode, M_icode}.
- mp = E_icode == 7 && !e_Cnd.
- exc = m_stat exception || W_stat exception.

FSM states: BOOT, RUN, HALT. State, the 4-bit boot counter and cpu_stat are registers. All control outputs are combinational from state plus inputs, valid in the same cycle, and sampled by the pipeline registers at the next posedge.

Reset (rst_n low, asynchronous):
- state = BOOT, boot counter = 0, cpu_stat = 1, halted = 0, counters = 0.
- Outputs while held in reset: F_stall = 1, D/E/M_bubble = 1, D_stall = 0, W_stall = 0, set_cc = 0.
- Reset asserted in any state, including mid-stall or mid-HALT, returns to BOOT.

BOOT:
- Outputs: F_stall = 1, D_bubble = E_bubble = M_bubble = 1, D_stall = 0, W_stall = 0, set_cc = 0.
- Counter increments each posedge; on the edge where counter == BOOT_CYCLES-1, go to RUN.
- Hazard and status inputs are ignored.

RUN:
- F_stall = lu || ret
- D_stall = lu
- D_bubble = mp || (!lu && ret)
- E_bubble = mp || lu
- M_bubble = exc
- W_stall = W_stat exception
- set_cc = E_icode == 6 && !exc
- Priority on simultaneous events: D_stall dominates D_bubble, so lu+ret gives stall, not bubble. mp with ret: D_bubble = 1, F_stall = 1.
- If W_stat is an exception at a posedge: latch cpu_stat = W_stat, go to HALT. m_stat alone does not transition.

HALT (sticky until reset):
- F_stall = D_stall = W_stall = 1, E_bubble = M_bubble = 1, D_bubble = 0, set_cc = 0.
- halted = 1; cpu_stat holds its value.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - perf_cycles increments every posedge in RUN.
  - perf_stalls increments in RUN when D_stall = 1 or (ret && !mp).
  - perf_mispred increments in RUN when mp = 1.
  - All three are 32-bit, wrap from 0xFFFFFFFF to 0, are cleared by reset, and freeze in HALT and BOOT.
- Undefined: no counter registers are built; the perf_* ports are tied to 0.

Test Plan:
- Reset release with BOOT_CYCLES=4: F_stall=1 and D/E/M_bubble=1 for exactly 4 posedges, then RUN with all outputs 0 and idle inputs (icodes=1, stat=1).
- Load/use: E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Same with E_dstM=15 and d_srcA=15 -> all 0.
- Ret: M_icode=9 -> F_stall=1, D_bubble=1. Add lu (E_icode=11, E_dstM=4, d_srcA=4) -> D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1. e_Cnd=1 -> both 0.
- Exception: E_icode=6 with m_stat=2 -> set_cc=0, M_bubble=1. Next cycle W_stat=2 -> W_stall=1; after posedge halted=1, cpu_stat=2 and outputs hold in HALT regardless of inputs. rst_n low mid-HALT -> BOOT immediately, cpu_stat=1.
- With PIPE_PERF_CNT_EN: 10 RUN cycles containing 2 lu and 1 mp -> perf_cycles=10, perf_stalls=2, perf_mispred=1. Preload perf_cycles to 0xFFFFFFFF -> next RUN cycle reads 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Hazard inputs, pipeline-register controls and performance
//               counters exchanged between the Y86-64 datapath and its
//               control unit.
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int STAT_W = 3
);
    logic [3:0]        D_icode;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [3:0]        E_icode;
    logic [3:0]        E_dstM;
    logic              e_Cnd;
    logic [3:0]        M_icode;
    logic [STAT_W-1:0] m_stat;
    logic [STAT_W-1:0] W_stat;

    logic              F_stall;
    logic              D_stall;
    logic              D_bubble;
    logic              E_bubble;
    logic              M_bubble;
    logic              W_stall;
    logic              set_cc;
    logic              halted;
    logic [STAT_W-1:0] cpu_stat;
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stalls;
    logic [31:0]       perf_mispred;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
               m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, cpu_stat, perf_cycles, perf_stalls, perf_mispred
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
               m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, cpu_stat, perf_cycles, perf_stalls, perf_mispred
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Y86-64 five-stage pipeline control: load/use, ret, mispredict
//               and exception handling with boot flush and sticky halt.
//               Optional performance counters under PIPE_PERF_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int STAT_W      = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [3:0]        C_MRMOVQ    = 4'd5;
    localparam logic [3:0]        C_OPQ       = 4'd6;
    localparam logic [3:0]        C_JXX       = 4'd7;
    localparam logic [3:0]        C_RET       = 4'd9;
    localparam logic [3:0]        C_POPQ      = 4'd11;
    localparam logic [3:0]        C_RNONE     = 4'd15;
    localparam logic [3:0]        C_BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [STAT_W-1:0] C_AOK       = STAT_W'(1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [STAT_W-1:0] cpu_stat_q, cpu_stat_d;

    logic w_lu, w_ret, w_mp, w_m_exc, w_w_exc, w_exc;
    logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall, w_set_cc;

    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == STAT_W'(2)) || (s == STAT_W'(3)) || (s == STAT_W'(4));
    endfunction

    always_comb begin
        w_lu    = ((bus.E_icode == C_MRMOVQ) || (bus.E_icode == C_POPQ)) &&
                  (bus.E_dstM != C_RNONE) &&
                  ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        w_ret   = (bus.D_icode == C_RET) || (bus.E_icode == C_RET) || (bus.M_icode == C_RET);
        w_mp    = (bus.E_icode == C_JXX) && !bus.e_Cnd;
        w_m_exc = is_exc(bus.m_stat);
        w_w_exc = is_exc(bus.W_stat);
        w_exc   = w_m_exc || w_w_exc;
    end

    // Held-in-reset outputs equal BOOT outputs because reset forces S_BOOT.
    always_comb begin
        w_f_stall  = 1'b1;
        w_d_stall  = 1'b0;
        w_d_bubble = 1'b1;
        w_e_bubble = 1'b1;
        w_m_bubble = 1'b1;
        w_w_stall  = 1'b0;
        w_set_cc   = 1'b0;
        case (state_q)
            S_RUN: begin
                w_f_stall  = w_lu || w_ret;
                w_d_stall  = w_lu;
                w_d_bubble = w_mp || (!w_lu && w_ret);
                w_e_bubble = w_mp || w_lu;
                w_m_bubble = w_exc;
                w_w_stall  = w_w_exc;
                w_set_cc   = (bus.E_icode == C_OPQ) && !w_exc;
            end
            S_HALT: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_d_bubble = 1'b0;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
                w_w_stall  = 1'b1;
                w_set_cc   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        cpu_stat_d = cpu_stat_q;
        case (state_q)
            S_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == C_BOOT_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_w_exc) begin
                    state_d    = S_HALT;
                    cpu_stat_d = bus.W_stat;
                end
            end
            S_HALT:  ;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= 4'd0;
            cpu_stat_q <= C_AOK;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            cpu_stat_q <= cpu_stat_d;
        end
    end

    assign bus.F_stall  = w_f_stall;
    assign bus.D_stall  = w_d_stall;
    assign bus.D_bubble = w_d_bubble;
    assign bus.E_bubble = w_e_bubble;
    assign bus.M_bubble = w_m_bubble;
    assign bus.W_stall  = w_w_stall;
    assign bus.set_cc   = w_set_cc;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.cpu_stat = cpu_stat_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_cycles_q,  perf_cycles_d;
    logic [31:0] perf_stalls_q,  perf_stalls_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    // Counters only advance in RUN; BOOT and HALT freeze them.
    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_stalls_d  = perf_stalls_q;
        perf_mispred_d = perf_mispred_q;
        if (state_q == S_RUN) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
            if (w_d_stall || (w_ret && !w_mp)) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
            if (w_mp) begin
                perf_mispred_d = perf_mispred_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q  <= 32'd0;
            perf_stalls_q  <= 32'd0;
            perf_mispred_q <= 32'd0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_stalls_q  <= perf_stalls_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    assign bus.perf_cycles  = perf_cycles_q;
    assign bus.perf_stalls  = perf_stalls_q;
    assign bus.perf_mispred = perf_mispred_q;
`else
    assign bus.perf_cycles  = 32'd0;
    assign bus.perf_stalls  = 32'd0;
    assign bus.perf_mispred = 32'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed-vector scoreboard bench for pipe_hazard_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int STAT_W = 3;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
    localparam logic [7:0] C_BOOT = 8'b1011_1000;
    localparam logic [7:0] C_HALT = 8'b1101_1101;
    localparam logic [7:0] C_IDLE = 8'b0000_0000;

    typedef struct {
        string             name;
        logic [7:0]        ctrl;
        logic [STAT_W-1:0] stat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    pipe_hazard_ctrl_if #(.STAT_W(STAT_W)) bus ();

    pipe_hazard_ctrl #(.BOOT_CYCLES(4), .STAT_W(STAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                   bus.M_bubble, bus.W_stall, bus.set_cc, bus.halted};
            total++;
            if (act !== e.ctrl || bus.cpu_stat !== e.stat) begin
                bad++;
                $display("FAIL %s: got ctrl=%b stat=%0d, want ctrl=%b stat=%0d",
                         e.name, act, bus.cpu_stat, e.ctrl, e.stat);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.D_icode = 4'd1;
        bus.d_srcA  = 4'd15;
        bus.d_srcB  = 4'd15;
        bus.E_icode = 4'd1;
        bus.E_dstM  = 4'd15;
        bus.e_Cnd   = 1'b1;
        bus.M_icode = 4'd1;
        bus.m_stat  = 3'd1;
        bus.W_stat  = 3'd1;
    endtask

    task automatic expect_v(input string n, input logic [7:0] c, input logic [STAT_W-1:0] s);
        exp_t e;
        e.name = n;
        e.ctrl = c;
        e.stat = s;
        sb.push_back(e);
    endtask

    task automatic check_perf(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", n, act, want);
        end
    endtask

    // Reset release followed by exactly four BOOT cycles, then idle RUN.
    task automatic boot_seq();
        cyc(); rst_n = 1'b1; idle(); expect_v("boot0", C_BOOT, 3'd1);
        cyc(); expect_v("boot1", C_BOOT, 3'd1);
        cyc(); expect_v("boot2", C_BOOT, 3'd1);
        cyc(); expect_v("boot3", C_BOOT, 3'd1);
        cyc(); expect_v("run_idle", C_IDLE, 3'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        cyc(); expect_v("in_reset", C_BOOT, 3'd1);
        cyc(); bus.E_icode = 4'd5; bus.E_dstM = 4'd3; bus.d_srcB = 4'd3;
        expect_v("in_reset_lu_ignored", C_BOOT, 3'd1);
        boot_seq();

        cyc(); idle(); bus.E_icode = 4'd5; bus.E_dstM = 4'd3; bus.d_srcB = 4'd3;
        expect_v("lu_mrmovq", 8'b1101_0000, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd5; bus.E_dstM = 4'd15; bus.d_srcA = 4'd15;
        expect_v("lu_dst_none", C_IDLE, 3'd1);
        cyc(); idle(); bus.M_icode = 4'd9;
        expect_v("ret_m", 8'b1010_0000, 3'd1);
        cyc(); idle(); bus.M_icode = 4'd9; bus.E_icode = 4'd11; bus.E_dstM = 4'd4; bus.d_srcA = 4'd4;
        expect_v("ret_plus_lu", 8'b1101_0000, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd7; bus.e_Cnd = 1'b0;
        expect_v("mispredict", 8'b0011_0000, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd7; bus.e_Cnd = 1'b0; bus.D_icode = 4'd9;
        expect_v("mp_plus_ret", 8'b1011_0000, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd7; bus.e_Cnd = 1'b1;
        expect_v("jxx_taken", C_IDLE, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd6;
        expect_v("opq_setcc", 8'b0000_0010, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd6; bus.m_stat = 3'd2;
        expect_v("opq_m_adr", 8'b0000_1000, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd6; bus.m_stat = 3'd5;
        expect_v("m_stat5_not_exc", 8'b0000_0010, 3'd1);
        cyc(); idle(); bus.W_stat = 3'd2;
        expect_v("w_adr", 8'b0000_1100, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd7; bus.e_Cnd = 1'b0; bus.M_icode = 4'd9;
        expect_v("halt_entry", C_HALT, 3'd2);
        cyc(); idle(); bus.E_icode = 4'd6; bus.W_stat = 3'd3;
        expect_v("halt_sticky", C_HALT, 3'd2);
        cyc(); rst_n = 1'b0;
        expect_v("reset_mid_halt", C_BOOT, 3'd1);

        boot_seq();
        // Ten RUN cycles: idle run already counted as one, nine more below.
        cyc(); idle(); bus.E_icode = 4'd5; bus.E_dstM = 4'd2; bus.d_srcA = 4'd2;
        expect_v("perf_lu1", 8'b1101_0000, 3'd1);
        cyc(); idle(); expect_v("perf_idle1", C_IDLE, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd11; bus.E_dstM = 4'd7; bus.d_srcB = 4'd7;
        expect_v("perf_lu2", 8'b1101_0000, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd7; bus.e_Cnd = 1'b0;
        expect_v("perf_mp", 8'b0011_0000, 3'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(); idle(); expect_v("perf_idle_n", C_IDLE, 3'd1);
        end
        cyc(); idle();
`ifdef PIPE_PERF_CNT_EN
        check_perf("perf_cycles", bus.perf_cycles, 32'd10);
        check_perf("perf_stalls", bus.perf_stalls, 32'd2);
        check_perf("perf_mispred", bus.perf_mispred, 32'd1);
`else
        check_perf("perf_cycles_off", bus.perf_cycles, 32'd0);
        check_perf("perf_stalls_off", bus.perf_stalls, 32'd0);
        check_perf("perf_mispred_off", bus.perf_mispred, 32'd0);
`endif
        bus.W_stat = 3'd4;
        expect_v("w_hlt", 8'b0000_1100, 3'd1);
        cyc(); idle(); bus.E_icode = 4'd5; bus.E_dstM = 4'd1; bus.d_srcA = 4'd1;
        expect_v("halt_hlt", C_HALT, 3'd4);
        cyc(); idle(); expect_v("halt_hlt_hold", C_HALT, 3'd4);
        cyc(); cyc();
`ifdef PIPE_PERF_CNT_EN
        check_perf("perf_cycles_frozen", bus.perf_cycles, 32'd11);
`else
        check_perf("perf_cycles_frozen_off", bus.perf_cycles, 32'd0);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
